// File: rtl/elbeth_pkg.sv
// Shared encodings and default widths for the elbeth memory-side blocks.
package elbeth_pkg;

  localparam int unsigned ADDR_W_DEF  = 8;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/elbeth_timeout_ctr.sv
// Clear/enable counter that flags expiry on its last permitted cycle; TIMEOUT = 0 disables it.
module elbeth_timeout_ctr #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [CW-1:0] SAT  = CW'(TIMEOUT);

  logic [CW-1:0] count_q;

  // Saturates at TIMEOUT instead of wrapping so a stuck enable can never re-arm expiry.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_q <= '0;
    end else if (en && (TIMEOUT != 0) && (count_q != SAT)) begin
      count_q <= count_q + 1'b1;
    end
  end

  always_comb begin
    expire = (TIMEOUT != 0) && (count_q == LAST);
  end

endmodule

// File: rtl/elbeth_mem_arbiter.sv
// Merges the core's instruction and data ports onto one single-port memory with
// alternating arbitration, registered forwarding and a per-transaction timeout.
module elbeth_mem_arbiter
  import elbeth_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                imem_en,
  input  logic [ADDR_W-1:0]   imem_addr,
  input  logic [DATA_W/8-1:0] imem_rw,
  input  logic [DATA_W-1:0]   imem_wdata,
  output logic [DATA_W-1:0]   imem_rdata,
  output logic                imem_ready,
  output logic                imem_error,
  input  logic                dmem_en,
  input  logic [ADDR_W-1:0]   dmem_addr,
  input  logic [DATA_W/8-1:0] dmem_rw,
  input  logic [DATA_W-1:0]   dmem_wdata,
  output logic [DATA_W-1:0]   dmem_rdata,
  output logic                dmem_ready,
  output logic                dmem_error,
  output logic                mem_en,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_rw,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready,
  input  logic                mem_error
);

  localparam int unsigned BE_W = DATA_W / 8;

  state_e state_q, state_d;
  logic   last_grant_q, last_grant_d;

  logic              req_any, pick, busy, done, expire, ctr_clr;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_error;

  logic              mem_en_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [BE_W-1:0]   mem_rw_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic [DATA_W-1:0] imem_rdata_d, dmem_rdata_d;
  logic              imem_ready_d, dmem_ready_d, imem_error_d, dmem_error_d;

  assign req_any = imem_en | dmem_en;
  // Under contention, hand the grant to whichever port did not win last time.
  assign pick    = (imem_en && dmem_en) ? ~last_grant_q : (dmem_en ? GRANT_D : GRANT_I);
  assign busy    = (state_q == ST_BUSY_I) || (state_q == ST_BUSY_D);
  assign done    = busy && (mem_ready || expire);
  assign ctr_clr = (state_q == ST_IDLE);

  // An abort completes with zero data and a forced error.
  assign rsp_rdata = mem_ready ? mem_rdata : '0;
  assign rsp_error = mem_ready ? mem_error : 1'b1;

  elbeth_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk    (clk),
    .rst    (rst),
    .clr    (ctr_clr),
    .en     (busy),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_any) state_d = (pick == GRANT_D) ? ST_BUSY_D : ST_BUSY_I;
      end
      ST_BUSY_I, ST_BUSY_D: begin
        if (done) state_d = ST_RESP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    last_grant_d = last_grant_q;
    mem_en_d     = mem_en;
    mem_addr_d   = mem_addr;
    mem_rw_d     = mem_rw;
    mem_wdata_d  = mem_wdata;
    imem_rdata_d = imem_rdata;
    imem_error_d = imem_error;
    imem_ready_d = 1'b0;
    dmem_rdata_d = dmem_rdata;
    dmem_error_d = dmem_error;
    dmem_ready_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_any) begin
          mem_en_d     = 1'b1;
          last_grant_d = pick;
          if (pick == GRANT_D) begin
            mem_addr_d  = dmem_addr;
            mem_rw_d    = dmem_rw;
            mem_wdata_d = dmem_wdata;
          end else begin
            mem_addr_d  = imem_addr;
            mem_rw_d    = imem_rw;
            mem_wdata_d = imem_wdata;
          end
        end
      end
      ST_BUSY_I: begin
        if (done) begin
          mem_en_d = 1'b0;
          // A master that abandoned its request gets no completion.
          if (imem_en) begin
            imem_ready_d = 1'b1;
            imem_rdata_d = rsp_rdata;
            imem_error_d = rsp_error;
          end
        end
      end
      ST_BUSY_D: begin
        if (done) begin
          mem_en_d = 1'b0;
          if (dmem_en) begin
            dmem_ready_d = 1'b1;
            dmem_rdata_d = rsp_rdata;
            dmem_error_d = rsp_error;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= GRANT_I;
      mem_en       <= 1'b0;
      mem_addr     <= '0;
      mem_rw       <= '0;
      mem_wdata    <= '0;
      imem_rdata   <= '0;
      imem_ready   <= 1'b0;
      imem_error   <= 1'b0;
      dmem_rdata   <= '0;
      dmem_ready   <= 1'b0;
      dmem_error   <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      mem_en       <= mem_en_d;
      mem_addr     <= mem_addr_d;
      mem_rw       <= mem_rw_d;
      mem_wdata    <= mem_wdata_d;
      imem_rdata   <= imem_rdata_d;
      imem_ready   <= imem_ready_d;
      imem_error   <= imem_error_d;
      dmem_rdata   <= dmem_rdata_d;
      dmem_ready   <= dmem_ready_d;
      dmem_error   <= dmem_error_d;
    end
  end

endmodule

// File: tb/tb_elbeth_mem_arbiter.sv
// Directed bench for elbeth_mem_arbiter with a simple one-cycle memory responder.
module tb_elbeth_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_en, dmem_en;
  logic [7:0]  imem_addr, dmem_addr;
  logic [3:0]  imem_rw, dmem_rw;
  logic [31:0] imem_wdata, dmem_wdata;
  logic [31:0] imem_rdata, dmem_rdata;
  logic        imem_ready, dmem_ready, imem_error, dmem_error;
  logic        mem_en;
  logic [7:0]  mem_addr;
  logic [3:0]  mem_rw;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready, mem_error;

  int          n_checks = 0;
  int          n_errors = 0;
  bit          auto_resp = 1'b1;
  bit          seen = 1'b0;
  logic [31:0] resp_data = '0;
  bit          resp_err = 1'b0;

  always #5 clk = ~clk;

  elbeth_mem_arbiter #(
    .ADDR_W  (8),
    .DATA_W  (32),
    .TIMEOUT (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_en    (imem_en),
    .imem_addr  (imem_addr),
    .imem_rw    (imem_rw),
    .imem_wdata (imem_wdata),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .imem_error (imem_error),
    .dmem_en    (dmem_en),
    .dmem_addr  (dmem_addr),
    .dmem_rw    (dmem_rw),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ready (dmem_ready),
    .dmem_error (dmem_error),
    .mem_en     (mem_en),
    .mem_addr   (mem_addr),
    .mem_rw     (mem_rw),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .mem_error  (mem_error)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory answers on the cycle after it first sees mem_en.
  task automatic mem_model();
    if (!auto_resp) return;
    if (mem_en && !mem_ready) begin
      if (seen) begin
        mem_ready = 1'b1;
        mem_rdata = resp_data;
        mem_error = resp_err;
        seen      = 1'b0;
      end else begin
        seen = 1'b1;
      end
    end else begin
      mem_ready = 1'b0;
      mem_error = 1'b0;
      seen      = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    mem_model();
  endtask

  task automatic run_txn(input bit is_d, input logic [7:0] addr, input logic [31:0] rdata,
                         input bit err);
    resp_data = rdata;
    resp_err  = err;
    if (is_d) begin
      dmem_en = 1'b1; dmem_addr = addr; dmem_rw = 4'h0;
    end else begin
      imem_en = 1'b1; imem_addr = addr; imem_rw = 4'h0;
    end
    step();
    check_eq("txn_mem_en", mem_en, 1);
    check_eq("txn_mem_addr", mem_addr, addr);
    step();
    check_eq("txn_early_ready", is_d ? dmem_ready : imem_ready, 0);
    step();
    check_eq("txn_ready", is_d ? dmem_ready : imem_ready, 1);
    check_eq("txn_rdata", is_d ? dmem_rdata : imem_rdata, rdata);
    check_eq("txn_error", is_d ? dmem_error : imem_error, err);
    check_eq("txn_mem_en_drop", mem_en, 0);
    imem_en = 1'b0;
    dmem_en = 1'b0;
    step();
    check_eq("txn_ready_pulse", is_d ? dmem_ready : imem_ready, 0);
  endtask

  initial begin
    rst        = 1'b1;
    imem_en    = 1'b1; imem_addr = 8'h10; imem_rw = 4'h0;    imem_wdata = 32'h0;
    dmem_en    = 1'b1; dmem_addr = 8'h20; dmem_rw = 4'b0011; dmem_wdata = 32'h0000_1234;
    mem_rdata  = '0;
    mem_ready  = 1'b0;
    mem_error  = 1'b0;

    // Reset held with both requests asserted
    for (int i = 0; i < 2; i++) begin
      step();
      check_eq("rst_mem_en", mem_en, 0);
      check_eq("rst_readies", {imem_ready, dmem_ready, imem_error, dmem_error}, 0);
      check_eq("rst_mem_addr", mem_addr, 0);
    end
    rst = 1'b0;

    // Contention: D wins first since last_grant resets to IMEM
    for (int t = 0; t < 4; t++) begin
      bit is_d;
      is_d      = (t % 2 == 0);
      resp_data = 32'hA000_0000 + t;
      step();
      check_eq("cont_mem_en", mem_en, 1);
      check_eq("cont_mem_addr", mem_addr, is_d ? 8'h20 : 8'h10);
      check_eq("cont_mem_rw", mem_rw, is_d ? 4'b0011 : 4'b0000);
      check_eq("cont_mem_wdata", mem_wdata, is_d ? 32'h0000_1234 : 32'h0);
      step();
      step();
      check_eq("cont_dmem_ready", dmem_ready, is_d);
      check_eq("cont_imem_ready", imem_ready, !is_d);
      if (!is_d) check_eq("cont_imem_rdata", imem_rdata, 32'hA000_0000 + t);
      if (t == 3) begin
        imem_en = 1'b0;
        dmem_en = 1'b0;
      end
      step();
    end

    // Single read, then memory error followed by a clean transaction
    run_txn(1'b0, 8'h10, 32'hDEAD_BEEF, 1'b0);
    run_txn(1'b0, 8'h14, 32'h1111_2222, 1'b1);
    run_txn(1'b0, 8'h18, 32'h3333_4444, 1'b0);
    run_txn(1'b1, 8'h24, 32'h5555_6666, 1'b0);

    // Timeout: memory never answers
    auto_resp = 1'b0;
    dmem_en   = 1'b1; dmem_addr = 8'h30; dmem_rw = 4'h0;
    step();
    check_eq("to_mem_en_first", mem_en, 1);
    for (int i = 1; i < 16; i++) step();
    check_eq("to_mem_en_last", mem_en, 1);
    check_eq("to_no_early_ready", dmem_ready, 0);
    step();
    check_eq("to_mem_en_drop", mem_en, 0);
    check_eq("to_dmem_ready", dmem_ready, 1);
    check_eq("to_dmem_error", dmem_error, 1);
    check_eq("to_dmem_rdata", dmem_rdata, 0);
    check_eq("to_imem_ready", imem_ready, 0);
    dmem_en = 1'b0;
    step();
    step();
    step();
    mem_ready = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    step();
    mem_ready = 1'b0;
    check_eq("late_ready_d", dmem_ready, 0);
    check_eq("late_ready_i", imem_ready, 0);
    check_eq("late_mem_en", mem_en, 0);
    check_eq("late_rdata_hold", dmem_rdata, 0);
    check_eq("late_error_hold", dmem_error, 1);
    step();
    check_eq("late_ready_d2", dmem_ready, 0);

    // Reset during the second busy cycle, then re-arbitration
    imem_en = 1'b1; imem_addr = 8'h44; imem_rw = 4'h0;
    step();
    check_eq("mid_mem_en", mem_en, 1);
    step();
    rst = 1'b1;
    step();
    check_eq("mid_rst_mem_en", mem_en, 0);
    check_eq("mid_rst_ready", imem_ready, 0);
    check_eq("mid_rst_derr", dmem_error, 0);
    rst = 1'b0;
    step();
    check_eq("rearb_mem_en", mem_en, 1);
    check_eq("rearb_mem_addr", mem_addr, 8'h44);
    check_eq("rearb_no_ready", imem_ready, 0);
    auto_resp = 1'b1;
    resp_data = 32'hCAFE_F00D;
    resp_err  = 1'b0;
    step();
    step();
    step();
    check_eq("rearb_ready", imem_ready, 1);
    check_eq("rearb_rdata", imem_rdata, 32'hCAFE_F00D);
    imem_en = 1'b0;
    step();
    check_eq("rearb_pulse", imem_ready, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
